// File: rtl/lmem_pkg.sv
// Shared types and constants for the layer-memory arbiter.
package lmem_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 20;

  // Layer-memory bank select codes
  localparam logic [2:0] CSEL_NONE  = 3'b000;
  localparam logic [2:0] CSEL_L0_K0 = 3'b001;
  localparam logic [2:0] CSEL_L0_K1 = 3'b010;
  localparam logic [2:0] CSEL_L1_K0 = 3'b011;
  localparam logic [2:0] CSEL_L1_K1 = 3'b100;
  localparam logic [2:0] CSEL_L2    = 3'b101;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} arb_state_t;

  // Codes 000, 110 and 111 select no bank; such transfers are swallowed.
  function automatic logic csel_legal(input logic [2:0] sel);
    return (sel >= CSEL_L0_K0) && (sel <= CSEL_L2);
  endfunction

endpackage

// File: rtl/lmem_arbiter_if.sv
// Requester and memory-port signals of the layer-memory arbiter.
// slave: arbiter side, master: requesters plus memory side.
interface lmem_arbiter_if
  import lmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [1:0]        req_i;
  logic [1:0]        lock_i;
  logic [1:0]        we_i;
  logic [2:0]        sel0_i;
  logic [2:0]        sel1_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic [2:0]        csel;

  modport slave (
    input  req_i, lock_i, we_i, sel0_i, sel1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, cdata_rd,
    output gnt_o, rvalid_o, rdata_o, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport master (
    output req_i, lock_i, we_i, sel0_i, sel1_i, addr0_i, addr1_i, wdata0_i, wdata1_i, cdata_rd,
    input  gnt_o, rvalid_o, rdata_o, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/lmem_hold_cnt.sv
// Saturating hold counter; at_max_o marks the cycle that completes MAX_BURST held cycles.
module lmem_hold_cnt #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; saturate at MAX_BURST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntW'(MAX_BURST))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q >= CntW'(MAX_BURST - 1));

endmodule

// File: rtl/lmem_arbiter.sv
// Two-requester arbiter for the layer-memory port. All memory-side outputs are registered.
// Define LMEM_ARB_RR_EN for round-robin IDLE tie-break; otherwise requester 0 wins ties.
module lmem_arbiter
  import lmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            reset,
  lmem_arbiter_if.slave   bus
);

  arb_state_t state_q, state_d, tie_pick;
  logic [1:0] gnt;
  logic       acc, acc_id, we_a, legal, at_max, hold_inc;
  logic [2:0] sel_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;

  logic              cwr_q, cwr_d, crd_q, crd_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d, rdata_q, rdata_d;
  logic [2:0]        csel_q, csel_d;
  logic              rd_pend_q, rd_pend_d, rd_id_q, rd_id_d;
  logic [1:0]        rvalid_q, rvalid_d;

  assign gnt     = {state_q == StOwn1, state_q == StOwn0};
  assign acc     = |(bus.req_i & gnt);
  assign acc_id  = gnt[1];
  assign we_a    = acc_id ? bus.we_i[1]   : bus.we_i[0];
  assign sel_a   = acc_id ? bus.sel1_i    : bus.sel0_i;
  assign addr_a  = acc_id ? bus.addr1_i   : bus.addr0_i;
  assign wdata_a = acc_id ? bus.wdata1_i  : bus.wdata0_i;
  assign legal   = csel_legal(sel_a);

`ifdef LMEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // Track the most recent grantee so the next IDLE tie goes to the other side.
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == StOwn0 && state_q != StOwn0)      last_owner_d = 1'b0;
    else if (state_d == StOwn1 && state_q != StOwn1) last_owner_d = 1'b1;
  end

  // Last-owner register.
  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= 1'b1;
    else       last_owner_q <= last_owner_d;
  end

  assign tie_pick = last_owner_q ? StOwn0 : StOwn1;
`else
  assign tie_pick = StOwn0;
`endif

  // Hold cycles only count while the other side is waiting.
  assign hold_inc = ((state_q == StOwn0) && bus.req_i[1]) ||
                    ((state_q == StOwn1) && bus.req_i[0]);

  lmem_hold_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_d != state_q),
    .inc_i    (hold_inc),
    .at_max_o (at_max)
  );

  // Grant FSM next state; preemption overrides lock and release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (&bus.req_i)        state_d = tie_pick;
        else if (bus.req_i[0]) state_d = StOwn0;
        else if (bus.req_i[1]) state_d = StOwn1;
      end
      StOwn0: begin
        if (at_max && bus.req_i[1])                  state_d = StOwn1;
        else if (!bus.req_i[0] && !bus.lock_i[0])    state_d = StIdle;
      end
      StOwn1: begin
        if (at_max && bus.req_i[0])                  state_d = StOwn0;
        else if (!bus.req_i[1] && !bus.lock_i[1])    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory command issue and read-data return pipeline.
  always_comb begin
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    caddr_wr_d = caddr_wr_q;
    caddr_rd_d = caddr_rd_q;
    cdata_wr_d = cdata_wr_q;
    csel_d     = csel_q;
    rd_pend_d  = 1'b0;
    rd_id_d    = rd_id_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    if (acc) begin
      if (we_a) begin
        if (legal) begin
          cwr_d      = 1'b1;
          caddr_wr_d = addr_a;
          cdata_wr_d = wdata_a;
          csel_d     = sel_a;
        end
      end else begin
        // Illegal-sel reads still return an rvalid, with zero data.
        rd_pend_d = 1'b1;
        rd_id_d   = acc_id;
        if (legal) begin
          crd_d      = 1'b1;
          caddr_rd_d = addr_a;
          csel_d     = sel_a;
        end
      end
    end
    if (rd_pend_q) begin
      rvalid_d = rd_id_q ? 2'b10 : 2'b01;
      rdata_d  = crd_q ? bus.cdata_rd : '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= CSEL_NONE;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cwr_q      <= cwr_d;
      crd_q      <= crd_d;
      caddr_wr_q <= caddr_wr_d;
      caddr_rd_q <= caddr_rd_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q     <= csel_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.cwr      = cwr_q;
  assign bus.crd      = crd_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.csel     = csel_q;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Directed bench for lmem_arbiter with a per-cycle scoreboard of memory commands and returns.
module tb_lmem_arbiter;
  import lmem_pkg::*;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int         due;
    logic       cwr;
    logic       crd;
    logic [11:0] addr;
    logic [19:0] data;
    logic [2:0]  sel;
  } mem_exp_t;

  typedef struct {
    int          due;
    logic [1:0]  rvalid;
    logic [19:0] rdata;
  } ret_exp_t;

  mem_exp_t mem_q[$];
  ret_exp_t ret_q[$];

  lmem_arbiter_if #(.ADDR_W(12), .DATA_W(20)) bus ();

  lmem_arbiter #(
    .ADDR_W    (12),
    .DATA_W    (20),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_mem(input int due, input logic cwr, input logic crd,
                          input logic [11:0] addr, input logic [19:0] data, input logic [2:0] sel);
    mem_exp_t m;
    m.due = due; m.cwr = cwr; m.crd = crd; m.addr = addr; m.data = data; m.sel = sel;
    mem_q.push_back(m);
  endtask

  task automatic push_ret(input int due, input logic [1:0] rvalid, input logic [19:0] rdata);
    ret_exp_t r;
    r.due = due; r.rvalid = rvalid; r.rdata = rdata;
    ret_q.push_back(r);
  endtask

  // Compare memory-side outputs of the current cycle against the scoreboard.
  task automatic check_cycle();
    mem_exp_t m;
    ret_exp_t r;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      m = mem_q.pop_front();
      chk("cwr", bus.cwr, m.cwr);
      chk("crd", bus.crd, m.crd);
      if (m.cwr) begin
        chk("caddr_wr", bus.caddr_wr, m.addr);
        chk("cdata_wr", bus.cdata_wr, m.data);
        chk("csel_wr", bus.csel, m.sel);
      end
      if (m.crd) begin
        chk("caddr_rd", bus.caddr_rd, m.addr);
        chk("csel_rd", bus.csel, m.sel);
      end
    end else begin
      chk("cwr_idle", bus.cwr, 1'b0);
      chk("crd_idle", bus.crd, 1'b0);
    end
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      chk("rvalid", bus.rvalid_o, r.rvalid);
      chk("rdata", bus.rdata_o, r.rdata);
    end else begin
      chk("rvalid_idle", bus.rvalid_o, 2'b00);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, bus.gnt_o, 2'b00);
    chk({tag, "_rvalid"}, bus.rvalid_o, 2'b00);
    chk({tag, "_rdata"}, bus.rdata_o, 20'h0);
    chk({tag, "_cwr"}, bus.cwr, 1'b0);
    chk({tag, "_crd"}, bus.crd, 1'b0);
    chk({tag, "_caddr_wr"}, bus.caddr_wr, 12'h0);
    chk({tag, "_caddr_rd"}, bus.caddr_rd, 12'h0);
    chk({tag, "_cdata_wr"}, bus.cdata_wr, 20'h0);
    chk({tag, "_csel"}, bus.csel, 3'b000);
  endtask

  initial begin
    logic [1:0] exp_gnt;
    bus.req_i = '0; bus.lock_i = '0; bus.we_i = '0;
    bus.sel0_i = '0; bus.sel1_i = '0; bus.addr0_i = '0; bus.addr1_i = '0;
    bus.wdata0_i = '0; bus.wdata1_i = '0; bus.cdata_rd = '0;
    reset = 1'b1;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Single writer: grant next cycle, cwr the cycle after.
    bus.we_i = 2'b01; bus.sel0_i = CSEL_L0_K0; bus.addr0_i = 12'h005; bus.wdata0_i = 20'h01310;
    bus.req_i = 2'b01;
    push_mem(cyc + 2, 1'b1, 1'b0, 12'h005, 20'h01310, CSEL_L0_K0);
    tick(); chk("wr_gnt", bus.gnt_o, 2'b01);
    tick(); bus.req_i = 2'b00;
    tick(); chk("wr_release", bus.gnt_o, 2'b00);

    // Read return on requester 1.
    bus.we_i = 2'b00; bus.sel1_i = CSEL_L0_K0; bus.addr1_i = 12'h041; bus.cdata_rd = 20'hABCDE;
    bus.req_i = 2'b10;
    push_mem(cyc + 2, 1'b0, 1'b1, 12'h041, 20'h0, CSEL_L0_K0);
    push_ret(cyc + 3, 2'b10, 20'hABCDE);
    tick(); chk("rd_gnt", bus.gnt_o, 2'b10);
    tick(); bus.req_i = 2'b00;
    tick(); chk("rd_release", bus.gnt_o, 2'b00);
    bus.cdata_rd = 20'h12345;

    // Illegal sel write: accepted, no cwr, bank/address hold.
    bus.we_i = 2'b01; bus.sel0_i = 3'b111; bus.addr0_i = 12'h077; bus.wdata0_i = 20'hFFFFF;
    bus.req_i = 2'b01;
    push_mem(cyc + 2, 1'b0, 1'b0, 12'h0, 20'h0, 3'b000);
    tick(); chk("ill_wr_gnt", bus.gnt_o, 2'b01);
    tick(); bus.req_i = 2'b00;
    chk("ill_wr_csel_hold", bus.csel, CSEL_L0_K0);
    chk("ill_wr_addr_hold", bus.caddr_wr, 12'h005);
    tick();

    // Illegal sel read: rvalid with zero data, no crd.
    bus.we_i = 2'b00; bus.sel0_i = CSEL_NONE; bus.addr0_i = 12'h099;
    bus.req_i = 2'b01;
    push_mem(cyc + 2, 1'b0, 1'b0, 12'h0, 20'h0, 3'b000);
    push_ret(cyc + 3, 2'b01, 20'h0);
    tick(); chk("ill_rd_gnt", bus.gnt_o, 2'b01);
    tick(); bus.req_i = 2'b00;
    tick();

    // Tie from reset: runs of 4 alternating owners, no idle gap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.we_i = 2'b11; bus.sel0_i = CSEL_L0_K0; bus.sel1_i = CSEL_L1_K1;
    bus.addr0_i = 12'h100; bus.addr1_i = 12'h200;
    bus.wdata0_i = 20'hA0A0A; bus.wdata1_i = 20'hB0B0B;
    bus.req_i = 2'b11;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_gnt = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
      chk("tie_gnt", bus.gnt_o, exp_gnt);
      if (exp_gnt == 2'b10) push_mem(cyc + 1, 1'b1, 1'b0, 12'h200, 20'hB0B0B, CSEL_L1_K1);
      else                  push_mem(cyc + 1, 1'b1, 1'b0, 12'h100, 20'hA0A0A, CSEL_L0_K0);
    end
    tick(); chk("tie_wrap_gnt", bus.gnt_o, 2'b01);
    bus.req_i = 2'b00;
    tick(); chk("tie_release", bus.gnt_o, 2'b00);

    // Lock holds OWN0 while idle; a new requester waits exactly MAX_BURST cycles.
    bus.we_i = 2'b01; bus.sel0_i = CSEL_L0_K1; bus.addr0_i = 12'h0AB; bus.wdata0_i = 20'h0C0DE;
    bus.req_i = 2'b01;
    push_mem(cyc + 2, 1'b1, 1'b0, 12'h0AB, 20'h0C0DE, CSEL_L0_K1);
    tick(); chk("lock_gnt", bus.gnt_o, 2'b01);
    tick(); bus.req_i = 2'b00; bus.lock_i = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("lock_hold", bus.gnt_o, 2'b01);
    end
    bus.we_i = 2'b11; bus.sel1_i = CSEL_L2; bus.addr1_i = 12'h3FF; bus.wdata1_i = 20'h5A5A5;
    bus.req_i = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick(); chk("lock_wait", bus.gnt_o, 2'b01);
    end
    tick(); chk("lock_preempt", bus.gnt_o, 2'b10);
    push_mem(cyc + 1, 1'b1, 1'b0, 12'h3FF, 20'h5A5A5, CSEL_L2);
    tick(); bus.req_i = 2'b00; bus.lock_i = 2'b00;
    tick(); chk("lock_release", bus.gnt_o, 2'b00);

    // Reset right after a read acceptance: no rvalid afterwards.
    bus.we_i = 2'b00; bus.sel1_i = CSEL_L1_K0; bus.addr1_i = 12'h123; bus.cdata_rd = 20'h55555;
    bus.req_i = 2'b10;
    push_mem(cyc + 2, 1'b0, 1'b1, 12'h123, 20'h0, CSEL_L1_K0);
    tick(); chk("rst_rd_gnt", bus.gnt_o, 2'b10);
    tick(); bus.req_i = 2'b00; reset = 1'b1;
    tick(); reset = 1'b0;
    chk_reset_vals("midrd_reset");
    tick();
    tick();

    chk("mem_q_drained", mem_q.size(), 0);
    chk("ret_q_drained", ret_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
